// File: rtl/memory_access_lsu.sv
// rtl/memory_access_lsu.sv - MIPS MEM stage: byte-addressed load/store unit, MEM/WB register, debug read port
module memory_access_lsu #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8,
    parameter int NB_REG  = 5
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_stall,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_REG-1:0]  i_reg2write,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_mem2reg,
    input  logic               i_regWrite,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    output logic [NB_DATA-1:0] o_reg_read,
    output logic [NB_DATA-1:0] o_ALUresult,
    output logic [NB_REG-1:0]  o_reg2write,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic               o_misaligned,
    output logic [NB_DATA-1:0] o_exc_addr
);

    // The lane logic below assumes four byte lanes, so NB_DATA is fixed at 32.
    localparam int DEPTH = 1 << NB_ADDR;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    logic [NB_DATA-1:0] mem [DEPTH];

    logic [1:0]         lane;
    logic [NB_ADDR-1:0] word_idx;
    logic               access;
    logic               bad_align;
    logic               trap;
    logic               advance;
    logic [3:0]         be;
    logic [NB_DATA-1:0] wdata;
    logic [NB_DATA-1:0] rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [NB_DATA-1:0] load_data;

    // Address bits above the RAM depth are deliberately ignored (the address wraps).
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_result[NB_DATA-1:NB_ADDR+2];

    assign lane     = i_result[1:0];
    assign word_idx = i_result[NB_ADDR+1:2];
    assign access   = i_memRead | i_memWrite;
    assign advance  = !i_stall && !i_halt;

    // Alignment check: illegal width, odd halfword, or word not on a 4-byte boundary.
    always_comb begin
        bad_align = 1'b0;
        case (i_width)
            W_BYTE:  bad_align = 1'b0;
            W_HALF:  bad_align = lane[0];
            W_WORD:  bad_align = (lane != 2'b00);
            default: bad_align = 1'b1;
        endcase
    end

    assign trap = access & bad_align;

    // Store lane enables and the replicated write word.
    always_comb begin
        be    = 4'b0000;
        wdata = i_data4Mem;
        case (i_width)
            W_BYTE: begin
                be    = 4'b0001 << lane;
                wdata = {4{i_data4Mem[7:0]}};
            end
            W_HALF: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_data4Mem[15:0]}};
            end
            W_WORD: begin
                be    = 4'b1111;
                wdata = i_data4Mem;
            end
            default: begin
                be    = 4'b0000;
                wdata = i_data4Mem;
            end
        endcase
    end

    // RAM write port: only enabled byte lanes change; contents survive reset.
    always_ff @(posedge clk) begin
        if (advance && i_memWrite && !trap) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous word read; a same-edge store is not yet visible, so old data is returned.
    assign rd_word = mem[word_idx];

    // Lane selection for sub-word loads (little-endian: lane 0 is bits 7:0).
    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    // Sign or zero extension; word loads pass straight through.
    always_comb begin
        load_data = rd_word;
        case (i_width)
            W_BYTE:  load_data = {{24{i_sign_flag & rd_byte[7]}}, rd_byte};
            W_HALF:  load_data = {{16{i_sign_flag & rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // MEM/WB pipeline register plus sticky trap capture; frozen while stalled or halted.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_reg_read   <= '0;
            o_ALUresult  <= '0;
            o_reg2write  <= '0;
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_misaligned <= 1'b0;
            o_exc_addr   <= '0;
        end else if (advance) begin
            o_reg_read  <= load_data;
            o_ALUresult <= i_result;
            o_reg2write <= i_reg2write;
            o_mem2reg   <= i_mem2reg;
            o_regWrite  <= i_regWrite & !trap;
            if (trap && !o_misaligned) begin
                o_misaligned <= 1'b1;
                o_exc_addr   <= i_result;
            end
        end
    end

    // Debug read port keeps running through stall and halt.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dbg_data <= '0;
        end else begin
            o_dbg_data <= mem[i_dbg_addr];
        end
    end

endmodule

// File: tb/tb_memory_access_lsu.sv
// tb/tb_memory_access_lsu.sv - scoreboard bench for memory_access_lsu
module tb_memory_access_lsu;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_halt;
    logic [31:0] i_result;
    logic [31:0] i_data4Mem;
    logic [4:0]  i_reg2write;
    logic [1:0]  i_width;
    logic        i_sign_flag;
    logic        i_memRead;
    logic        i_memWrite;
    logic        i_mem2reg;
    logic        i_regWrite;
    logic [7:0]  i_dbg_addr;
    logic [31:0] o_reg_read;
    logic [31:0] o_ALUresult;
    logic [4:0]  o_reg2write;
    logic        o_mem2reg;
    logic        o_regWrite;
    logic [31:0] o_dbg_data;
    logic        o_misaligned;
    logic [31:0] o_exc_addr;

    memory_access_lsu #(.NB_DATA(32), .NB_ADDR(8), .NB_REG(5)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_stall      (i_stall),
        .i_halt       (i_halt),
        .i_result     (i_result),
        .i_data4Mem   (i_data4Mem),
        .i_reg2write  (i_reg2write),
        .i_width      (i_width),
        .i_sign_flag  (i_sign_flag),
        .i_memRead    (i_memRead),
        .i_memWrite   (i_memWrite),
        .i_mem2reg    (i_mem2reg),
        .i_regWrite   (i_regWrite),
        .i_dbg_addr   (i_dbg_addr),
        .o_reg_read   (o_reg_read),
        .o_ALUresult  (o_ALUresult),
        .o_reg2write  (o_reg2write),
        .o_mem2reg    (o_mem2reg),
        .o_regWrite   (o_regWrite),
        .o_dbg_data   (o_dbg_data),
        .o_misaligned (o_misaligned),
        .o_exc_addr   (o_exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] alu;
        logic        rw;
        logic [4:0]  r2w;
        logic        m2r;
        logic        chk;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_alu = '0;
    logic        last_rw  = 1'b0;
    logic [4:0]  last_r2w = '0;
    logic        last_m2r = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one MEM-stage operation at the falling edge and queue what the MEM/WB regs must show after the next rising edge.
    task automatic op(input string tag, input logic [31:0] addr, input logic [31:0] d,
                      input logic [1:0] w, input logic sg, input logic rd, input logic wr,
                      input logic rw, input logic st, input logic hl,
                      input logic chk, input logic [31:0] exp_d, input logic exp_rw);
        sb_t e;
        @(negedge clk);
        i_result    = addr;
        i_data4Mem  = d;
        i_width     = w;
        i_sign_flag = sg;
        i_memRead   = rd;
        i_memWrite  = wr;
        i_regWrite  = rw;
        i_mem2reg   = rd;
        i_reg2write = rw ? 5'd9 : 5'd0;
        i_stall     = st;
        i_halt      = hl;
        if (!st && !hl) begin
            last_alu = addr;
            last_rw  = exp_rw;
            last_r2w = rw ? 5'd9 : 5'd0;
            last_m2r = rd;
        end
        e.tag  = tag;
        e.alu  = last_alu;
        e.rw   = last_rw;
        e.r2w  = last_r2w;
        e.m2r  = last_m2r;
        e.chk  = chk && !st && !hl;
        e.data = exp_d;
        sb_q.push_back(e);
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] d, input logic [1:0] w);
        op(tag, addr, d, w, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] w, input logic sg, input logic [31:0] exp_d);
        op(tag, addr, 32'h0, w, sg, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_d, 1'b1);
    endtask

    task automatic idle();
        op("idle", 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_reg_read"}, o_reg_read, 32'h0);
        check({tag, "_alu"}, o_ALUresult, 32'h0);
        check({tag, "_r2w"}, {27'h0, o_reg2write}, 32'h0);
        check({tag, "_m2r"}, {31'h0, o_mem2reg}, 32'h0);
        check({tag, "_rw"}, {31'h0, o_regWrite}, 32'h0);
        check({tag, "_dbg"}, o_dbg_data, 32'h0);
        check({tag, "_mis"}, {31'h0, o_misaligned}, 32'h0);
        check({tag, "_exc"}, o_exc_addr, 32'h0);
    endtask

    // Scoreboard consumer: one queued expectation per rising edge.
    always begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            check({e.tag, "_alu"}, o_ALUresult, e.alu);
            check({e.tag, "_rw"}, {31'h0, o_regWrite}, {31'h0, e.rw});
            check({e.tag, "_r2w"}, {27'h0, o_reg2write}, {27'h0, e.r2w});
            check({e.tag, "_m2r"}, {31'h0, o_mem2reg}, {31'h0, e.m2r});
            if (e.chk) check({e.tag, "_data"}, o_reg_read, e.data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0; i_stall = 1'b0; i_halt = 1'b0;
        i_result = '0; i_data4Mem = '0; i_reg2write = '0; i_width = 2'b10;
        i_sign_flag = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0;
        i_mem2reg = 1'b0; i_regWrite = 1'b0; i_dbg_addr = 8'h10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        i_rst_n = 1'b1;

        // word store / load
        store("sw_dead", 32'h10, 32'hDEADBEEF, 2'b10);
        load("lw_dead", 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);

        // byte store into a known word, byte loads both extensions
        store("sw_1122", 32'h10, 32'h11223344, 2'b10);
        store("sb_a5", 32'h13, 32'h000000A5, 2'b00);
        load("lw_a5", 32'h10, 2'b10, 1'b0, 32'hA5223344);
        load("lb_a5", 32'h13, 2'b00, 1'b1, 32'hFFFFFFA5);
        load("lbu_a5", 32'h13, 2'b00, 1'b0, 32'h000000A5);
        load("lb_44", 32'h10, 2'b00, 1'b1, 32'h00000044);
        load("lw_signign", 32'h10, 2'b10, 1'b1, 32'hA5223344);

        // halfword store into the upper lane
        store("sw_1234", 32'h20, 32'h12345678, 2'b10);
        store("sh_8001", 32'h22, 32'h00008001, 2'b01);
        load("lh_8001", 32'h22, 2'b01, 1'b1, 32'hFFFF8001);
        load("lhu_8001", 32'h22, 2'b01, 1'b0, 32'h00008001);
        load("lw_8001", 32'h20, 2'b10, 1'b0, 32'h80015678);
        load("lbu_56", 32'h21, 2'b00, 1'b0, 32'h00000056);

        // misaligned accesses
        store("sw_cafe", 32'h30, 32'hCAFEF00D, 2'b10);
        idle();
        @(posedge clk); #2;
        check("mis_before", {31'h0, o_misaligned}, 32'h0);
        op("lw_mis", 32'h12, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle();
        @(posedge clk); #2;
        check("mis_set", {31'h0, o_misaligned}, 32'h1);
        check("exc_first", o_exc_addr, 32'h12);
        store("sh_mis", 32'h31, 32'h0000BEEF, 2'b01);
        op("ill_w", 32'h34, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle();
        @(posedge clk); #2;
        check("exc_sticky", o_exc_addr, 32'h12);
        load("lw_nowrite", 32'h30, 2'b10, 1'b0, 32'hCAFEF00D);

        // stall / halt suppress the store and hold the pipeline regs
        store("sw_99", 32'h40, 32'h00000099, 2'b10);
        idle();
        op("sw_stall1", 32'h40, 32'h55, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        op("sw_halt", 32'h40, 32'h55, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        op("sw_stall2", 32'h40, 32'h55, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #2;
        check("dbg_stalled", o_dbg_data, 32'h00000099);
        op("lw_mis_stall", 32'h42, 32'h0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        store("sw_55", 32'h40, 32'h00000055, 2'b10);
        @(posedge clk); #2;
        check("dbg_same_edge", o_dbg_data, 32'h00000099);
        idle();
        @(posedge clk); #2;
        check("dbg_after", o_dbg_data, 32'h00000055);
        check("exc_after_stall", o_exc_addr, 32'h12);
        load("lw_55", 32'h40, 2'b10, 1'b0, 32'h00000055);

        // address wrap: bits above the RAM depth are ignored
        load("lw_wrap", 32'h00000440, 2'b10, 1'b0, 32'h00000055);

        // asynchronous reset in mid-stream
        load("lw_prerst", 32'h10, 2'b10, 1'b0, 32'hA5223344);
        @(posedge clk); #3;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        i_rst_n = 1'b1;
        idle();
        @(posedge clk); #2;
        check("dbg_keep_40", o_dbg_data, 32'h00000055);
        @(negedge clk);
        i_dbg_addr = 8'h04;
        @(posedge clk); #2;
        check("dbg_keep_10", o_dbg_data, 32'hA5223344);
        check("mis_cleared", {31'h0, o_misaligned}, 32'h0);

        @(posedge clk); #2;
        check("sb_drain", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
